// File: rtl/sim_video_out.sv
// rtl/sim_video_out.sv - video output stage: ce_pix generation, colour widening, sync normalisation
// and beam/active-width counters for the simulation harness.
module sim_video_out #(
  parameter int IN_BITS    = 3,
  parameter int OUT_BITS   = 8,
  parameter int CE_MODE    = 1,
  parameter int CE_DIV     = 4,
  parameter int HS_POL_IN  = 1,
  parameter int VS_POL_IN  = 1,
  parameter int BLANK_ZERO = 1,
  parameter int CNT_W      = 12
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 pix_clk_in,
  input  logic [3*IN_BITS-1:0] rgb_in,
  input  logic                 hs_in,
  input  logic                 vs_in,
  input  logic                 hb_in,
  input  logic                 vb_in,
  output logic                 ce_pix,
  output logic [OUT_BITS-1:0]  VGA_R,
  output logic [OUT_BITS-1:0]  VGA_G,
  output logic [OUT_BITS-1:0]  VGA_B,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 VGA_HB,
  output logic                 VGA_VB,
  output logic [CNT_W-1:0]     hcount,
  output logic [CNT_W-1:0]     vcount,
  output logic [15:0]          frame_count,
  output logic [CNT_W-1:0]     active_width,
  output logic                 frame_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic ce_next;

  generate
    if (CE_MODE == 0) begin : g_div
      logic [4:0] div;
      always_ff @(posedge clk_sys) begin
        if (reset || div == 5'(CE_DIV - 1)) div <= '0;
        else                                div <= div + 5'd1;
      end
      assign ce_next = (div == 5'(CE_DIV - 1));
    end else begin : g_edge
      logic old;
      always_ff @(posedge clk_sys) begin
        if (reset) old <= 1'b0;
        else       old <= pix_clk_in;
      end
      assign ce_next = old & ~pix_clk_in;
    end
  endgenerate

  always_ff @(posedge clk_sys) begin
    if (reset) ce_pix <= 1'b0;
    else       ce_pix <= ce_next;
  end

  logic [IN_BITS-1:0]  r_in, g_in, b_in;
  logic [OUT_BITS-1:0] r_w, g_w, b_w;

  assign r_in = rgb_in[IN_BITS-1:0];
  assign g_in = rgb_in[2*IN_BITS-1:IN_BITS];
  assign b_in = rgb_in[3*IN_BITS-1:2*IN_BITS];

  // MSB-first repetition of the input code fills the wider channel
  for (genvar i = 0; i < OUT_BITS; i++) begin : g_widen
    assign r_w[OUT_BITS-1-i] = r_in[IN_BITS-1-(i % IN_BITS)];
    assign g_w[OUT_BITS-1-i] = g_in[IN_BITS-1-(i % IN_BITS)];
    assign b_w[OUT_BITS-1-i] = b_in[IN_BITS-1-(i % IN_BITS)];
  end

  logic blank_rgb, hs_n, vs_n;
  logic hs_rise, vs_rise, hb_rise, hb_fall;

  assign blank_rgb = (BLANK_ZERO != 0) && (hb_in || vb_in);
  assign hs_n      = (HS_POL_IN != 0) ? hs_in : ~hs_in;
  assign vs_n      = (VS_POL_IN != 0) ? vs_in : ~vs_in;
  // Edges compare the value being captured against the one already on the outputs
  assign hs_rise   = hs_n & ~VGA_HS;
  assign vs_rise   = vs_n & ~VGA_VS;
  assign hb_rise   = hb_in & ~VGA_HB;
  assign hb_fall   = ~hb_in & VGA_HB;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
      VGA_HS <= 1'b0;
      VGA_VS <= 1'b0;
      VGA_HB <= 1'b0;
      VGA_VB <= 1'b0;
    end else if (ce_pix) begin
      VGA_R  <= blank_rgb ? '0 : r_w;
      VGA_G  <= blank_rgb ? '0 : g_w;
      VGA_B  <= blank_rgb ? '0 : b_w;
      VGA_HS <= hs_n;
      VGA_VS <= vs_n;
      VGA_HB <= hb_in;
      VGA_VB <= vb_in;
    end
  end

  logic [CNT_W-1:0] pix_cnt;

  always_ff @(posedge clk_sys) begin
    frame_done <= 1'b0;
    if (reset) begin
      hcount       <= '0;
      vcount       <= '0;
      frame_count  <= '0;
      active_width <= '0;
      pix_cnt      <= '0;
    end else if (ce_pix) begin
      if (hs_rise)                hcount <= '0;
      else if (hcount != CNT_MAX) hcount <= hcount + CNT_W'(1);

      if (vs_rise) begin
        vcount      <= '0;
        frame_count <= frame_count + 16'd1;
        frame_done  <= 1'b1;
      end else if (hs_rise && vcount != CNT_MAX) begin
        vcount <= vcount + CNT_W'(1);
      end

      // The first active pixel counts itself, so a cleared line starts at 1
      if (hb_fall)                            pix_cnt <= CNT_W'(1);
      else if (!hb_in && pix_cnt != CNT_MAX)  pix_cnt <= pix_cnt + CNT_W'(1);

      if (hb_rise) active_width <= pix_cnt;
    end
  end

endmodule

// File: tb/tb_sim_video_out.sv
// tb/tb_sim_video_out.sv - scoreboard bench for sim_video_out: ce timing, widening, blanking,
// sync normalisation, beam counters, active width and mid-line reset.
module tb_sim_video_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, reset_d, pix_clk_in;
  logic [8:0] rgb_in;
  logic       hs_in, vs_in, hb_in, vb_in;

  logic        ce_pix, vga_hs, vga_vs, vga_hb, vga_vb, frame_done;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic [11:0] hcount, vcount, active_width;
  logic [15:0] frame_count;

  logic        d_ce, d_hs, d_vs, d_hb, d_vb, d_fd;
  logic [7:0]  d_r, d_g, d_b;
  logic [11:0] d_hc, d_vc, d_aw;
  logic [15:0] d_fc;

  sim_video_out #(.IN_BITS(3), .OUT_BITS(8), .CE_MODE(1), .CE_DIV(4), .HS_POL_IN(0),
                  .VS_POL_IN(0), .BLANK_ZERO(1), .CNT_W(12)) u_dut (
    .clk_sys(clk), .reset(reset), .pix_clk_in(pix_clk_in), .rgb_in(rgb_in),
    .hs_in(hs_in), .vs_in(vs_in), .hb_in(hb_in), .vb_in(vb_in), .ce_pix(ce_pix),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b), .VGA_HS(vga_hs), .VGA_VS(vga_vs),
    .VGA_HB(vga_hb), .VGA_VB(vga_vb), .hcount(hcount), .vcount(vcount),
    .frame_count(frame_count), .active_width(active_width), .frame_done(frame_done));

  sim_video_out #(.IN_BITS(3), .OUT_BITS(8), .CE_MODE(0), .CE_DIV(4), .HS_POL_IN(1),
                  .VS_POL_IN(1), .BLANK_ZERO(1), .CNT_W(12)) u_div (
    .clk_sys(clk), .reset(reset_d), .pix_clk_in(1'b0), .rgb_in(9'd0),
    .hs_in(1'b0), .vs_in(1'b0), .hb_in(1'b0), .vb_in(1'b0), .ce_pix(d_ce),
    .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b), .VGA_HS(d_hs), .VGA_VS(d_vs),
    .VGA_HB(d_hb), .VGA_VB(d_vb), .hcount(d_hc), .vcount(d_vc),
    .frame_count(d_fc), .active_width(d_aw), .frame_done(d_fd));

  typedef struct {
    logic [7:0]  r, g, b;
    logic        hs, vs, hb, vb;
    logic [11:0] hc, vc;
    logic [15:0] fc;
    logic [11:0] aw;
    logic        fd;
    logic [5:0]  mask;  // 0 video, 1 hcount, 2 vcount, 3 frame_count, 4 active_width, 5 frame_done
    int          x, y;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_bad = 0;
  bit          pend = 1'b0;
  bit          bad;
  logic [15:0] exp_fc = '0;
  logic [11:0] exp_aw = '0;
  bit          aw_known = 1'b0;

  // 12 MHz pixel clock against a 48 MHz system clock: one period per 4 clk cycles
  int ph = 0;
  initial pix_clk_in = 1'b1;
  always @(posedge clk) begin
    #1;
    ph = (ph + 1) % 4;
    pix_clk_in = (ph < 2);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [7:0] w38(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  always @(negedge clk) begin
    if (pend && sb.size() > 0) begin
      mon_e = sb.pop_front();
      bad = 1'b0;
      if (mon_e.mask[0] && {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_hb, vga_vb} !==
          {mon_e.r, mon_e.g, mon_e.b, mon_e.hs, mon_e.vs, mon_e.hb, mon_e.vb}) bad = 1'b1;
      if (mon_e.mask[1] && hcount !== mon_e.hc) bad = 1'b1;
      if (mon_e.mask[2] && vcount !== mon_e.vc) bad = 1'b1;
      if (mon_e.mask[3] && frame_count !== mon_e.fc) bad = 1'b1;
      if (mon_e.mask[4] && active_width !== mon_e.aw) bad = 1'b1;
      if (mon_e.mask[5] && frame_done !== mon_e.fd) bad = 1'b1;
      n_vec++;
      if (bad) begin
        n_bad++;
        $display("FAIL pixel x=%0d y=%0d mask=%b: got rgb=%h/%h/%h s=%b%b%b%b hc=%0d vc=%0d fc=%0d aw=%0d fd=%b; want rgb=%h/%h/%h s=%b%b%b%b hc=%0d vc=%0d fc=%0d aw=%0d fd=%b",
                 mon_e.x, mon_e.y, mon_e.mask, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_hb, vga_vb,
                 hcount, vcount, frame_count, active_width, frame_done,
                 mon_e.r, mon_e.g, mon_e.b, mon_e.hs, mon_e.vs, mon_e.hb, mon_e.vb,
                 mon_e.hc, mon_e.vc, mon_e.fc, mon_e.aw, mon_e.fd);
      end
    end
    pend = ce_pix && !reset;
  end

  // Drive one pixel so that it is captured on the next ce_pix, and queue its expected output
  task automatic send(input logic [8:0] rgb, input logic hs, input logic vs,
                      input logic hb, input logic vb, input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (!ce_pix && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!ce_pix) begin
      n_vec++;
      n_bad++;
      $display("FAIL ce_wait: got no ce_pix within 16 cycles, want one");
      return;
    end
    rgb_in = rgb; hs_in = hs; vs_in = vs; hb_in = hb; vb_in = vb;
    sb.push_back(e);
  endtask

  function automatic exp_t mk_vid(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                  input logic hs, input logic vs, input logic hb, input logic vb,
                                  input logic fd);
    exp_t e;
    e = '{r: r, g: g, b: b, hs: hs, vs: vs, hb: hb, vb: vb, hc: '0, vc: '0, fc: '0, aw: '0,
          fd: fd, mask: 6'b100001, x: -1, y: -1};
    return e;
  endfunction

  // Frame generator: hsync rises at x=0 of every line, vsync at y=0; syncs driven active-low
  task automatic run_frame(input int ht, input int hsl, input int hst, input int hact,
                           input int vt, input int vsl, input int vact, input int maxp);
    int         np;
    logic       hsn, vsn, hb, vb;
    logic [8:0] pat;
    exp_t       e;
    np = 0;
    for (int y = 0; y < vt; y++) begin
      for (int x = 0; x < ht; x++) begin
        if (maxp > 0 && np >= maxp) return;
        np++;
        hsn = (x < hsl);
        vsn = (y < vsl);
        hb  = !(x >= hst && x < hst + hact);
        vb  = (y >= vact);
        pat = 9'((x * 5 + y * 3) % 512);
        if (x == 0 && y == 0) exp_fc = exp_fc + 16'd1;
        if (x == hst + hact) begin
          exp_aw = 12'(hact);
          aw_known = 1'b1;
        end
        e.r  = (hb || vb) ? 8'h00 : w38(pat[2:0]);
        e.g  = (hb || vb) ? 8'h00 : w38(pat[5:3]);
        e.b  = (hb || vb) ? 8'h00 : w38(pat[8:6]);
        e.hs = hsn; e.vs = vsn; e.hb = hb; e.vb = vb;
        e.hc = 12'(x); e.vc = 12'(y); e.fc = exp_fc; e.aw = exp_aw;
        e.fd = (x == 0 && y == 0);
        e.mask = aw_known ? 6'b111111 : 6'b101111;
        e.x = x; e.y = y;
        send(pat, ~hsn, ~vsn, hb, vb, e);
      end
    end
  endtask

  initial begin
    reset = 1'b1; reset_d = 1'b1;
    rgb_in = '0; hs_in = 1'b1; vs_in = 1'b1; hb_in = 1'b0; vb_in = 1'b0;

    // Divider mode: pulses on edges 4, 8, 12, 16 after release
    repeat (3) @(negedge clk);
    chk("div_ce_in_reset", 128'(d_ce), 128'(0));
    reset_d = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      chk($sformatf("div_ce_edge%0d", e), 128'(d_ce), 128'(e % 4 == 0));
    end

    chk("reset_outputs", 128'({ce_pix, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_hb, vga_vb,
        hcount, vcount, frame_count, active_width, frame_done}), 128'(0));
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // Falling-edge mode: pulse only in phase 3, one per pixel clock period
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      chk("ce_mode1_phase", 128'(ce_pix), 128'(ph == 3));
    end

    send({3'b111, 3'b011, 3'b101}, 1'b1, 1'b1, 1'b0, 1'b0,
         mk_vid(8'hB6, 8'h6D, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    send(9'h1FF, 1'b1, 1'b1, 1'b1, 1'b0, mk_vid(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    send(9'h1FF, 1'b1, 1'b1, 1'b0, 1'b0, mk_vid(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    send(9'h1FF, 1'b1, 1'b1, 1'b0, 1'b1, mk_vid(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    send({3'b010, 3'b110, 3'b001}, 1'b0, 1'b0, 1'b0, 1'b0,
         mk_vid(8'h24, 8'hDB, 8'h49, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
    send(9'h1FF, 1'b1, 1'b1, 1'b0, 1'b0, mk_vid(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_fc = 16'd1;

    run_frame(800, 96, 144, 640, 3, 2, 3, 0);
    run_frame(8, 2, 3, 4, 525, 2, 480, 0);
    run_frame(800, 96, 144, 640, 525, 2, 480, 301);
    repeat (3) @(negedge clk);
    chk("queue_drained_before_reset", 128'(sb.size()), 128'(0));

    reset = 1'b1;
    @(negedge clk);
    chk("midline_reset_outputs", 128'({ce_pix, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_hb, vga_vb,
        hcount, vcount, frame_count, active_width, frame_done}), 128'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_fc = '0; exp_aw = '0; aw_known = 1'b1;
    run_frame(8, 2, 3, 4, 525, 2, 480, 10);
    repeat (3) @(negedge clk);
    chk("queue_drained_at_end", 128'(sb.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
